color_bbox_stat: RTL and testbench

- Sits directly downstream of the colour-classification stage. It consumes the false-colour RGB565 pixel stream, one classified pixel per valid beat.
- For each of RECT_NUMMAX colour classes it accumulates a per-frame bounding box and pixel count.
- At each frame boundary (rising edge of i_post_camvs) it publishes the packed rectangle vector that the overlay/draw stage takes as its item input.

---
 rtl/color_bbox_stat.sv | 179 +++++++++++++++++
 tb/tb_color_bbox_stat.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/color_bbox_stat.sv
// Per-frame bounding box and pixel count for each colour class of a classified RGB565 stream.
// The packed rectangle vector is published at every rising edge of the frame sync.
module color_bbox_stat #(
  parameter int                           IMG_X       = 640,
  parameter int                           IMG_Y       = 480,
  parameter int                           P_W         = 12,
  parameter int                           RECT_NUMMAX = 4,
  parameter logic [RECT_NUMMAX*16-1:0]    CLASS_CODES = {16'h07E0, 16'h001F, 16'hF800, 16'h8410},
  parameter int                           SHIFT       = 2,
  parameter int                           CNT_W       = 20
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [CNT_W-1:0]          i_min_pix,
  input  logic                      i_post_camvs,
  input  logic                      i_valid,
  input  logic [15:0]               i_data,
  output logic [RECT_NUMMAX*32-1:0] o_item,
  output logic                      o_item_valid,
  output logic                      o_frame_err
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  localparam logic [P_W-1:0]   X_LAST = P_W'(IMG_X - 1);
  localparam logic [P_W-1:0]   Y_LAST = P_W'(IMG_Y - 1);
  localparam logic [P_W-1:0]   ONE_P  = 1;
  localparam logic [CNT_W-1:0] ONE_C  = 1;

  state_t                    state_q, state_d;
  logic                      camvs_q;
  logic [P_W-1:0]            cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic                      done_q, done_d, ovf_q, ovf_d;
  logic [P_W-1:0]            xmin_q [RECT_NUMMAX];
  logic [P_W-1:0]            xmin_d [RECT_NUMMAX];
  logic [P_W-1:0]            xmax_q [RECT_NUMMAX];
  logic [P_W-1:0]            xmax_d [RECT_NUMMAX];
  logic [P_W-1:0]            ymin_q [RECT_NUMMAX];
  logic [P_W-1:0]            ymin_d [RECT_NUMMAX];
  logic [P_W-1:0]            ymax_q [RECT_NUMMAX];
  logic [P_W-1:0]            ymax_d [RECT_NUMMAX];
  logic [CNT_W-1:0]          count_q [RECT_NUMMAX];
  logic [CNT_W-1:0]          count_d [RECT_NUMMAX];
  logic [RECT_NUMMAX*32-1:0] item_q, item_d;
  logic                      item_valid_q, item_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      vs_edge;
  logic                      accept;

  function automatic logic [7:0] pack8(input logic [P_W-1:0] v);
    logic [P_W+7:0] ext;
    ext = {8'h00, v >> SHIFT};
    return ext[7:0];
  endfunction

  assign vs_edge = i_post_camvs & ~camvs_q;

  always_comb begin
    state_d      = state_q;
    cnt_x_d      = cnt_x_q;
    cnt_y_d      = cnt_y_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    item_d       = item_q;
    item_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    accept       = 1'b0;
    for (int k = 0; k < RECT_NUMMAX; k++) begin
      xmin_d[k]  = xmin_q[k];
      xmax_d[k]  = xmax_q[k];
      ymin_d[k]  = ymin_q[k];
      ymax_d[k]  = ymax_q[k];
      count_d[k] = count_q[k];
    end

    if (state_q == S_ACCUM) begin
      accept = 1'b1;
      if (vs_edge) begin
        item_valid_d = 1'b1;
        frame_err_d  = ovf_q | ~done_q;
        for (int k = 0; k < RECT_NUMMAX; k++) begin
          if (count_q[k] >= i_min_pix && count_q[k] != '0)
            item_d[32*k +: 32] = {pack8(xmin_q[k]), pack8(ymin_q[k]),
                                  pack8(xmax_q[k]), pack8(ymax_q[k])};
          else
            item_d[32*k +: 32] = 32'h0;
        end
      end
    end else if (vs_edge) begin
      state_d = S_ACCUM;
      accept  = 1'b1;
    end

    // Clear comes first so a pixel in the edge cycle lands at (0,0) of the new frame.
    if (vs_edge) begin
      cnt_x_d = '0;
      cnt_y_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      for (int k = 0; k < RECT_NUMMAX; k++) begin
        xmin_d[k]  = '1;
        ymin_d[k]  = '1;
        xmax_d[k]  = '0;
        ymax_d[k]  = '0;
        count_d[k] = '0;
      end
    end

    if (accept && i_valid) begin
      if (done_d) begin
        ovf_d = 1'b1;
      end else begin
        for (int k = 0; k < RECT_NUMMAX; k++) begin
          if (i_data == CLASS_CODES[16*k +: 16]) begin
            if (cnt_x_d < xmin_d[k]) xmin_d[k] = cnt_x_d;
            if (cnt_x_d > xmax_d[k]) xmax_d[k] = cnt_x_d;
            if (cnt_y_d < ymin_d[k]) ymin_d[k] = cnt_y_d;
            if (cnt_y_d > ymax_d[k]) ymax_d[k] = cnt_y_d;
            if (count_d[k] != '1) count_d[k] = count_d[k] + ONE_C;
          end
        end
        if (cnt_x_d == X_LAST) begin
          cnt_x_d = '0;
          if (cnt_y_d == Y_LAST) begin
            cnt_y_d = '0;
            done_d  = 1'b1;
          end else begin
            cnt_y_d = cnt_y_d + ONE_P;
          end
        end else begin
          cnt_x_d = cnt_x_d + ONE_P;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      camvs_q      <= 1'b0;
      cnt_x_q      <= '0;
      cnt_y_q      <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      item_q       <= '0;
      item_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int k = 0; k < RECT_NUMMAX; k++) begin
        xmin_q[k]  <= '1;
        ymin_q[k]  <= '1;
        xmax_q[k]  <= '0;
        ymax_q[k]  <= '0;
        count_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      camvs_q      <= i_post_camvs;
      cnt_x_q      <= cnt_x_d;
      cnt_y_q      <= cnt_y_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      item_q       <= item_d;
      item_valid_q <= item_valid_d;
      frame_err_q  <= frame_err_d;
      for (int k = 0; k < RECT_NUMMAX; k++) begin
        xmin_q[k]  <= xmin_d[k];
        ymin_q[k]  <= ymin_d[k];
        xmax_q[k]  <= xmax_d[k];
        ymax_q[k]  <= ymax_d[k];
        count_q[k] <= count_d[k];
      end
    end
  end

  assign o_item       = item_q;
  assign o_item_valid = item_valid_q;
  assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_color_bbox_stat.sv
// Directed bench for color_bbox_stat: a beat-indexed model pushes expected rect vectors
// at each frame edge; a monitor pops and compares them on every o_item_valid pulse.
module tb_color_bbox_stat;
  localparam int IMG_X = 8;
  localparam int IMG_Y = 4;
  localparam int P_W   = 8;
  localparam int NR    = 4;
  localparam int CNT_W = 20;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst;
  logic [CNT_W-1:0]     i_min_pix;
  logic                 i_post_camvs;
  logic                 i_valid;
  logic [15:0]          i_data;
  logic [NR*32-1:0]     o_item;
  logic                 o_item_valid;
  logic                 o_frame_err;

  color_bbox_stat #(
    .IMG_X(IMG_X), .IMG_Y(IMG_Y), .P_W(P_W), .RECT_NUMMAX(NR),
    .CLASS_CODES({16'h8410, 16'hF800, 16'h001F, 16'h07E0}),
    .SHIFT(0), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_min_pix(i_min_pix),
    .i_post_camvs(i_post_camvs), .i_valid(i_valid), .i_data(i_data),
    .o_item(o_item), .o_item_valid(o_item_valid), .o_frame_err(o_frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [NR*32-1:0] item;
    logic             err;
  } exp_t;

  logic [15:0] code [NR];
  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pushes = 0;

  // model state: beat index within the frame, one box per class
  bit m_active;
  int m_beat;
  bit m_ovf;
  int m_cnt [NR];
  int m_xmin [NR];
  int m_xmax [NR];
  int m_ymin [NR];
  int m_ymax [NR];

  function automatic void m_clear();
    m_beat = 0;
    m_ovf  = 1'b0;
    for (int k = 0; k < NR; k++) begin
      m_cnt[k]  = 0;
      m_xmin[k] = 1000;
      m_ymin[k] = 1000;
      m_xmax[k] = -1;
      m_ymax[k] = -1;
    end
  endfunction

  function automatic void m_pixel(input logic [15:0] d);
    int x, y;
    if (!m_active) return;
    if (m_beat >= IMG_X * IMG_Y) begin
      m_ovf = 1'b1;
      return;
    end
    x = m_beat % IMG_X;
    y = m_beat / IMG_X;
    for (int k = 0; k < NR; k++) begin
      if (d == code[k]) begin
        m_cnt[k]++;
        if (x < m_xmin[k]) m_xmin[k] = x;
        if (x > m_xmax[k]) m_xmax[k] = x;
        if (y < m_ymin[k]) m_ymin[k] = y;
        if (y > m_ymax[k]) m_ymax[k] = y;
      end
    end
    m_beat++;
  endfunction

  function automatic void m_commit();
    exp_t e;
    e.item = '0;
    e.err  = m_ovf || (m_beat != IMG_X * IMG_Y);
    for (int k = 0; k < NR; k++) begin
      if (m_cnt[k] != 0 && m_cnt[k] >= int'(i_min_pix))
        e.item[32*k +: 32] = {8'(m_xmin[k]), 8'(m_ymin[k]), 8'(m_xmax[k]), 8'(m_ymax[k])};
    end
    sb_q.push_back(e);
    pushes++;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_pix(input logic [15:0] d);
    i_valid = 1'b1;
    i_data  = d;
    m_pixel(d);
    tick();
    i_valid = 1'b0;
    i_data  = 16'h0;
  endtask

  // n beats of background, with cd at beat indices a, b, c (-1 = unused)
  task automatic frame(input int n, input int a, input int b, input int c, input logic [15:0] cd);
    for (int i = 0; i < n; i++)
      drive_pix((i == a || i == b || i == c) ? cd : 16'hFFFF);
  endtask

  task automatic frame_edge(input bit with_pix, input logic [15:0] d);
    i_post_camvs = 1'b1;
    if (m_active) m_commit();
    m_active = 1'b1;
    m_clear();
    if (with_pix) begin
      i_valid = 1'b1;
      i_data  = d;
      m_pixel(d);
    end
    tick();
    i_post_camvs = 1'b0;
    i_valid      = 1'b0;
    i_data       = 16'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge sys_clk);
    checks++;
    assert (o_item === '0) else begin
      errors++; $error("FAIL %s_item observed=%h expected=0", tag, o_item);
    end
    checks++;
    assert (o_item_valid === 1'b0) else begin
      errors++; $error("FAIL %s_valid observed=%b expected=0", tag, o_item_valid);
    end
    checks++;
    assert (o_frame_err === 1'b0) else begin
      errors++; $error("FAIL %s_err observed=%b expected=0", tag, o_frame_err);
    end
  endtask

  always @(negedge sys_clk) begin
    if (o_item_valid === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_pulse observed=1 expected=0 item=%h", o_item);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        assert (o_item === mon_e.item) else begin
          errors++; $error("FAIL item observed=%h expected=%h", o_item, mon_e.item);
        end
        checks++;
        assert (o_frame_err === mon_e.err) else begin
          errors++; $error("FAIL frame_err observed=%b expected=%b", o_frame_err, mon_e.err);
        end
      end
    end
  end

  initial begin
    int p0;
    code[0] = 16'h07E0; code[1] = 16'h001F; code[2] = 16'hF800; code[3] = 16'h8410;
    m_active     = 1'b0;
    m_clear();
    sys_rst      = 1'b1;
    i_min_pix    = 20'd2;
    i_post_camvs = 1'b0;
    i_valid      = 1'b0;
    i_data       = 16'h0;
    check_reset_outputs("reset");
    tick();
    tick();
    sys_rst = 1'b0;
    tick();

    // first edge only arms accumulation
    frame_edge(1'b0, 16'h0);
    tick(); tick(); tick();
    checks++;
    assert (pulses === 0) else begin
      errors++; $error("FAIL first_edge_pulses observed=%0d expected=0", pulses);
    end
    checks++;
    assert (o_item === '0) else begin
      errors++; $error("FAIL first_edge_item observed=%h expected=0", o_item);
    end

    frame(32, -1, -1, -1, 16'h0);
    frame_edge(1'b0, 16'h0);               // empty frame
    frame(32, 10, 13, 27, 16'h07E0);
    frame_edge(1'b0, 16'h0);               // slot0 = 02_01_05_03
    frame(32, 20, -1, -1, 16'h001F);
    frame_edge(1'b0, 16'h0);               // single pixel below min
    frame(32, 20, -1, -1, 16'h001F);
    i_min_pix = 20'd1;
    frame_edge(1'b0, 16'h0);               // slot1 = 04_02_04_02
    i_min_pix = 20'd2;
    frame(30, -1, -1, -1, 16'h0);
    frame_edge(1'b0, 16'h0);               // short frame
    frame(34, 32, 33, -1, 16'hF800);
    frame_edge(1'b1, 16'h8410);            // overflow frame; 8410 lands at (0,0)
    frame(31, -1, -1, -1, 16'h0);
    frame_edge(1'b1, 16'h8410);            // count 1 < min 2
    frame(31, -1, -1, -1, 16'h0);
    i_min_pix = 20'd1;
    frame_edge(1'b0, 16'h0);               // box at origin, count 1
    frame(32, 9, -1, -1, 16'h07E0);
    frame_edge(1'b0, 16'h0);               // leaves o_item nonzero
    tick(); tick();

    // reset mid-frame
    frame(10, 3, -1, -1, 16'h07E0);
    sys_rst = 1'b1;
    m_active = 1'b0;
    m_clear();
    check_reset_outputs("mid_reset");
    check_reset_outputs("mid_reset");
    tick();
    sys_rst = 1'b0;
    tick();
    p0 = pulses;
    frame_edge(1'b0, 16'h0);
    frame(32, 0, 31, -1, 16'h8410);
    frame_edge(1'b0, 16'h0);               // slot3 = 00_00_07_03
    tick(); tick(); tick(); tick();
    checks++;
    assert (pulses === p0 + 1) else begin
      errors++; $error("FAIL post_reset_pulses observed=%0d expected=%0d", pulses - p0, 1);
    end

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++; $error("FAIL pending_results observed=%0d expected=0", sb_q.size());
    end
    checks++;
    assert (pulses === pushes) else begin
      errors++; $error("FAIL total_pulses observed=%0d expected=%0d", pulses, pushes);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
